relu: RTL and testbench

RELU -- requirements
Module: relu

---
 rtl/relu.sv | 86 ++++++++
 tb/tb_relu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/relu.sv
// relu: single-stage registered ReLU on IEEE-754 binary32 operands with a
// valid/ready handshake on both sides and a saturating count of clipped results.
// Ports: clk, rst_n (sync, active-low); data_in/in_valid/in_ready (input side);
//        out_ReLU/out_valid/out_ready (output side); clip_count (results forced to +0).
// Optional feature: define RELU_DENORM_FLUSH_EN to flush positive subnormals to +0
// (counted as clips); when undefined, positive subnormals pass through unchanged.
module relu #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_ReLU,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  clip_count
);

  localparam logic [DATA_WIDTH-1:0] CANON_QNAN = DATA_WIDTH'(32'h7FC0_0000);

  // binary32 field split
  logic        sign;
  logic [7:0]  expo;
  logic [22:0] mant;

  assign sign = data_in[31];
  assign expo = data_in[30:23];
  assign mant = data_in[22:0];

  logic                  is_nan;
  logic                  is_clip;
  logic [DATA_WIDTH-1:0] result;

  assign is_nan = (expo == 8'hFF) && (mant != 23'd0);

  // NaN is checked first so a negative NaN still yields the canonical quiet NaN
  // rather than being clipped to zero.
  always_comb begin
    result  = data_in;
    is_clip = 1'b0;
    if (is_nan) begin
      result = CANON_QNAN;
    end else if (sign) begin
      result  = '0;
      is_clip = 1'b1;
    end
`ifdef RELU_DENORM_FLUSH_EN
    else if ((expo == 8'd0) && (mant != 23'd0)) begin
      result  = '0;
      is_clip = 1'b1;
    end
`endif
  end

  logic in_xfer;
  logic out_xfer;

  // A new operand may enter whenever the output register is empty or is being
  // drained this cycle, so back-to-back transfers run at full rate.
  assign in_ready = !out_valid | out_ready;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ReLU   <= '0;
      clip_count <= '0;
    end else begin
      if (in_xfer) begin
        // Covers the simultaneous in/out case too: new result replaces old.
        out_ReLU  <= result;
        out_valid <= 1'b1;
        if (is_clip && (clip_count != {CNT_WIDTH{1'b1}})) begin
          clip_count <= clip_count + CNT_WIDTH'(1);
        end
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu.sv
// tb_relu: directed scoreboard bench for relu. Expected results are queued when
// an input transfer is seen and popped when the DUT completes an output transfer.
// A second instance with CNT_WIDTH=4 shares the stimulus to exercise saturation.
module tb_relu;

`ifdef RELU_DENORM_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_ReLU;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] clip_count;

  logic        in_ready_s;
  logic [31:0] out_relu_s;
  logic        out_valid_s;
  logic [3:0]  clip_count_s;

  relu #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .out_ReLU(out_ReLU), .out_valid(out_valid),
    .out_ready(out_ready), .clip_count(clip_count)
  );

  relu #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready_s), .out_ReLU(out_relu_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .clip_count(clip_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          model_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus: outputs/handshakes sampled on the falling edge,
  // counters checked just after the rising edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                      input logic [31:0] expv, input logic exp_clip);
    logic [31:0] front;
    int          sat;
    in_valid  = iv;
    data_in   = d;
    out_ready = ordy;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", out_ReLU, 32'hxxxx_xxxx);
      end else begin
        front = exp_q.pop_front();
        chk("out_relu", out_ReLU, front);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(expv);
      if (exp_clip) model_cnt++;
    end
    @(posedge clk);
    #1;
    sat = (model_cnt > 15) ? 15 : model_cnt;
    chk("clip_count", 32'(clip_count), 32'(model_cnt));
    chk("clip_count_sat4", 32'(clip_count_s), 32'(sat));
  endtask

  task automatic drain();
    step(1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    step(1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
  endtask

  logic [31:0] d;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = 32'h0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_during", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_relu", out_ReLU, 32'h0);
    chk("rst_clip_count", 32'(clip_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready_after", 32'(in_ready), 32'd1);

    // Basic stream at full throughput
    step(1'b1, 32'hC126_6666, 1'b1, 32'h0000_0000, 1'b1);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_data", out_ReLU, 32'h0000_0000);
    step(1'b1, 32'h40B3_3333, 1'b1, 32'h40B3_3333, 1'b0);
    step(1'b1, 32'h0000_0002, 1'b1, FLUSH ? 32'h0 : 32'h0000_0002, FLUSH);
    drain();
    chk("stream_clip_total", 32'(clip_count), FLUSH ? 32'd2 : 32'd1);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Special values
    step(1'b1, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1);
    step(1'b1, 32'hFF80_0000, 1'b1, 32'h0000_0000, 1'b1);
    step(1'b1, 32'h7F80_0000, 1'b1, 32'h7F80_0000, 1'b0);
    step(1'b1, 32'hFFC0_0001, 1'b1, 32'h7FC0_0000, 1'b0);
    step(1'b1, 32'h7F80_0001, 1'b1, 32'h7FC0_0000, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
    // data ignored while in_valid is low
    step(1'b0, 32'hBF80_0000, 1'b1, 32'h0, 1'b1);
    chk("idle_holds_data", out_ReLU, 32'h0000_0000);
    drain();

    // Backpressure then simultaneous transfer
    step(1'b1, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hBF80_0000 + 32'(i), 1'b0, 32'h0, 1'b1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_hold", out_ReLU, 32'h3F80_0000);
    end
    step(1'b1, 32'hBF80_0000, 1'b1, 32'h0000_0000, 1'b1);
    chk("simul_out_valid", 32'(out_valid), 32'd1);
    chk("simul_new_data", out_ReLU, 32'h0000_0000);
    step(1'b1, 32'h4120_0000, 1'b1, 32'h4120_0000, 1'b0);
    drain();

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      d[31] = 1'b1;
      if (d[30:23] == 8'hFF) d[30:23] = 8'hFE;
      step(1'b1, d, 1'b1, 32'h0000_0000, 1'b1);
    end
    drain();
    chk("sat4_value", 32'(clip_count_s), 32'hF);
    step(1'b1, 32'hC000_0000, 1'b1, 32'h0000_0000, 1'b1);
    drain();
    chk("sat4_holds", 32'(clip_count_s), 32'hF);

    // Reset while a result is pending
    step(1'b1, 32'h4000_0000, 1'b0, 32'h4000_0000, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("pend_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    data_in = 32'hC000_0000;
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_clip", 32'(clip_count), 32'd0);
    chk("midrst_clip_s", 32'(clip_count_s), 32'd0);
    chk("midrst_out_relu", out_ReLU, 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step(1'b1, 32'hC000_0000, 1'b1, 32'h0000_0000, 1'b1);
    drain();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
